// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute and drives all datapath selects and enables.
// Latency: 3-5 cycles per instruction with zero-wait memory; outputs are a combinational decode of state and inputs.
// Backpressure: FETCH, MRD and MWR hold mem_req and all their outputs until mem_ack.
module mc_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic [1:0] npc_sel,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [1:0] ext_op,
    output logic       instr_done,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_ALUWB  = 4'd3,
        S_MADDR  = 4'd4,
        S_MRD    = 4'd5,
        S_MWB    = 4'd6,
        S_MWR    = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t cur_state;
    state_t nxt_state;

    logic is_rtype;
    logic is_addu;
    logic is_subu;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_jal;

    assign is_rtype = (op == OP_RTYPE);
    assign is_addu  = is_rtype && (funct == FN_ADDU);
    assign is_subu  = is_rtype && (funct == FN_SUBU);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);

    assign state = cur_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        npc_sel    = 2'b00;
        reg_wr     = 1'b0;
        reg_dst    = 2'b00;
        wd_sel     = 2'b00;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        ext_op     = 2'b00;
        instr_done = 1'b0;
        halted     = 1'b0;

        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_wr     = 1'b1;
                    pc_wr     = 1'b1;
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_addu || is_subu || is_ori || is_lui) begin
                    nxt_state = S_EXE;
                end else if (is_lw || is_sw) begin
                    nxt_state = S_MADDR;
                end else if (is_beq) begin
                    nxt_state = S_BR;
                end else if (is_jr || is_j || is_jal) begin
                    nxt_state = S_JMP;
                end else if (ILLEGAL_TRAP) begin
                    nxt_state = S_HALT;
                end else begin
                    instr_done = 1'b1;
                    nxt_state  = S_FETCH;
                end
            end
            // ALUWB keeps the EXE ALU/extender setup so the result stays valid during writeback
            S_EXE, S_ALUWB: begin
                if (is_subu) begin
                    alu_op = 2'b01;
                end else if (is_ori) begin
                    alu_src = 1'b1;
                    alu_op  = 2'b10;
                    ext_op  = 2'b00;
                end else if (is_lui) begin
                    alu_src = 1'b1;
                    ext_op  = 2'b10;
                end
                if (cur_state == S_EXE) begin
                    nxt_state = S_ALUWB;
                end else begin
                    reg_wr     = 1'b1;
                    reg_dst    = is_rtype ? 2'b01 : 2'b00;
                    instr_done = 1'b1;
                    nxt_state  = S_FETCH;
                end
            end
            S_MADDR: begin
                alu_src   = 1'b1;
                ext_op    = 2'b01;
                nxt_state = is_sw ? S_MWR : S_MRD;
            end
            S_MRD: begin
                alu_src = 1'b1;
                ext_op  = 2'b01;
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack) begin
                    nxt_state = S_MWB;
                end
            end
            S_MWB: begin
                reg_wr     = 1'b1;
                wd_sel     = 2'b01;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MWR: begin
                alu_src = 1'b1;
                ext_op  = 2'b01;
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    instr_done = 1'b1;
                    nxt_state  = S_FETCH;
                end
            end
            S_BR: begin
                alu_op     = 2'b01;
                ext_op     = 2'b01;
                npc_sel    = 2'b01;
                pc_wr      = zero;
                instr_done = 1'b1;
                nxt_state  = S_FETCH;
            end
            // PC already holds PC+4 from FETCH, so jal links that value
            S_JMP: begin
                pc_wr      = 1'b1;
                npc_sel    = is_jr ? 2'b11 : 2'b10;
                instr_done = 1'b1;
                if (is_jal) begin
                    reg_wr  = 1'b1;
                    reg_dst = 2'b10;
                    wd_sel  = 2'b10;
                end
                nxt_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                nxt_state = S_FETCH;
            end
        endcase

        if (!reset) begin
            nxt_state  = S_FETCH;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_wr      = 1'b0;
            pc_wr      = 1'b0;
            npc_sel    = 2'b00;
            reg_wr     = 1'b0;
            reg_dst    = 2'b00;
            wd_sel     = 2'b00;
            alu_src    = 1'b0;
            alu_op     = 2'b00;
            ext_op     = 2'b00;
            instr_done = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule
